// File: rtl/bin2dig_8.sv
// Sequential binary-to-BCD converter (double dabble) feeding the 8-digit seven-segment bank.
// Produces one BCD digit per byte of oDIG; the output register only changes when a conversion completes.
module bin2dig_8 #(
  parameter int BIN_W   = 27,
  parameter int MAX_VAL = 99999999
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iSTART,
  input  logic [BIN_W-1:0] iBIN,
  output logic [63:0]      oDIG,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oOVF
);

  localparam int               CNT_W   = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [BIN_W-1:0] binReg;
  logic [31:0]      bcdReg;
  logic [CNT_W-1:0] bitCnt;
  logic             ovfReg;

  logic [31:0]      bcdAdj;
  logic [31:0]      bcdNext;
  logic [63:0]      digNext;

  // Per-nibble add-3 correction with no carry between digits, then the combined left shift.
  // The accumulator MSB falls off the top; it is always zero for in-range inputs.
  always_comb begin
    bcdAdj = bcdReg;
    for (int k = 0; k < 8; k++) begin
      if (bcdReg[4*k +: 4] >= 4'd5) begin
        bcdAdj[4*k +: 4] = bcdReg[4*k +: 4] + 4'd3;
      end
    end
    bcdNext = (bcdAdj << 1) | {31'b0, binReg[BIN_W-1]};
  end

  // Spread the eight BCD nibbles into bytes; an overflowed input saturates every digit to 9.
  always_comb begin
    digNext = '0;
    for (int k = 0; k < 8; k++) begin
      digNext[8*k +: 8] = ovfReg ? 8'h09 : {4'h0, bcdReg[4*k +: 4]};
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state  <= IDLE;
      binReg <= '0;
      bcdReg <= '0;
      bitCnt <= '0;
      ovfReg <= 1'b0;
      oDIG   <= '0;
      oBUSY  <= 1'b0;
      oDONE  <= 1'b0;
      oOVF   <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      case (state)
        IDLE: begin
          if (iSTART) begin
            binReg <= iBIN;
            bcdReg <= '0;
            bitCnt <= CNT_W'(BIN_W);
            ovfReg <= (iBIN > MAX_BIN);
            oBUSY  <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcdReg <= bcdNext;
          binReg <= binReg << 1;
          bitCnt <= bitCnt - CNT_W'(1);
          if (bitCnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          oDIG  <= digNext;
          oOVF  <= ovfReg;
          oDONE <= 1'b1;
          oBUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2dig_8.sv
// Directed self-checking bench for bin2dig_8: latency, boundary values, ignored starts,
// continuous start, and reset in the middle of a conversion.
module tb_bin2dig_8;

  logic        iCLK;
  logic        iRST_N;
  logic        iSTART;
  logic [26:0] iBIN;
  logic [63:0] oDIG;
  logic        oBUSY;
  logic        oDONE;
  logic        oOVF;

  int checks = 0;
  int errors = 0;

  bin2dig_8 dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iSTART(iSTART),
    .iBIN  (iBIN),
    .oDIG  (oDIG),
    .oBUSY (oBUSY),
    .oDONE (oDONE),
    .oOVF  (oOVF)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts one conversion, optionally pulses iSTART at sample indices pA/pB, scrambles iBIN
  // while busy, and observes a fixed 60-cycle window. k counts negedges after the accepting edge.
  task automatic applyStimulus(input logic [26:0] val, input int pA, input int pB,
                               output int lat, output int busyCnt, output int doneCnt,
                               output logic [63:0] digAtDone, output logic ovfAtDone,
                               output logic stableOk, output logic ovfAt10);
    logic [63:0] prevDig;
    lat = -1; busyCnt = 0; doneCnt = 0; digAtDone = 'x; ovfAtDone = 1'bx;
    stableOk = 1'b1; ovfAt10 = 1'bx;
    @(negedge iCLK);
    iSTART = 1'b1;
    iBIN   = val;
    @(posedge iCLK);
    prevDig = oDIG;
    for (int k = 0; k < 60; k++) begin
      @(negedge iCLK);
      if (oBUSY) busyCnt++;
      if (k == 10) ovfAt10 = oOVF;
      if (oDONE) begin
        doneCnt++;
        if (lat < 0) begin
          lat       = k;
          digAtDone = oDIG;
          ovfAtDone = oOVF;
        end
      end else if (oDIG !== prevDig) begin
        stableOk = 1'b0;
      end
      prevDig = oDIG;
      iSTART  = (k == pA || k == pB);
      iBIN    = 27'($urandom);
    end
    iSTART = 1'b0;
  endtask

  initial begin
    int lat, busyCnt, doneCnt, t1, t2, k;
    logic [63:0] dig, dig1, dig2;
    logic ovf, stable, ovf10;

    iRST_N = 1'b0;
    iSTART = 1'b0;
    iBIN   = '0;
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (8) @(negedge iCLK);
    checkOutput("rstDig", oDIG, 64'h0);
    checkOutput("rstBusy", {63'b0, oBUSY}, 64'h0);
    checkOutput("rstDone", {63'b0, oDONE}, 64'h0);
    checkOutput("rstOvf", {63'b0, oOVF}, 64'h0);

    applyStimulus(27'd12345678, -1, -1, lat, busyCnt, doneCnt, dig, ovf, stable, ovf10);
    checkOutput("mainLatency", 64'(lat), 64'd28);
    checkOutput("mainBusyCycles", 64'(busyCnt), 64'd28);
    checkOutput("mainDoneCount", 64'(doneCnt), 64'd1);
    checkOutput("mainDig", dig, 64'h0102030405060708);
    checkOutput("mainOvf", {63'b0, ovf}, 64'h0);
    checkOutput("mainStable", {63'b0, stable}, 64'h1);

    applyStimulus(27'd0, -1, -1, lat, busyCnt, doneCnt, dig, ovf, stable, ovf10);
    checkOutput("zeroDig", dig, 64'h0);
    checkOutput("zeroLatency", 64'(lat), 64'd28);

    applyStimulus(27'd99999999, -1, -1, lat, busyCnt, doneCnt, dig, ovf, stable, ovf10);
    checkOutput("maxDig", dig, 64'h0909090909090909);
    checkOutput("maxOvf", {63'b0, ovf}, 64'h0);

    applyStimulus(27'd100000000, -1, -1, lat, busyCnt, doneCnt, dig, ovf, stable, ovf10);
    checkOutput("ovfDig", dig, 64'h0909090909090909);
    checkOutput("ovfFlag", {63'b0, ovf}, 64'h1);

    // Extra starts mid-conversion and in the DONE cycle must be ignored; oOVF holds until completion.
    applyStimulus(27'd42, 5, 27, lat, busyCnt, doneCnt, dig, ovf, stable, ovf10);
    checkOutput("ignDig", dig, 64'h0000000000000402);
    checkOutput("ignDoneCount", 64'(doneCnt), 64'd1);
    checkOutput("ignLatency", 64'(lat), 64'd28);
    checkOutput("ignOvfHeld", {63'b0, ovf10}, 64'h1);
    checkOutput("ignOvfCleared", {63'b0, ovf}, 64'h0);
    checkOutput("ignStable", {63'b0, stable}, 64'h1);

    // iSTART held high: 9 then 10, completions 29 cycles apart.
    @(negedge iCLK);
    iSTART = 1'b1;
    iBIN   = 27'd9;
    @(posedge iCLK);
    @(negedge iCLK);
    iBIN = 27'd10;
    t1 = -1; t2 = -1; dig1 = 'x; dig2 = 'x; stable = 1'b1;
    k = 0;
    while (t2 < 0 && k < 80) begin
      if (oDONE) begin
        if (t1 < 0) begin t1 = k; dig1 = oDIG; end
        else begin t2 = k; dig2 = oDIG; end
      end else if (t1 >= 0 && oDIG !== dig1) begin
        stable = 1'b0;
      end
      if (t2 < 0) begin
        @(negedge iCLK);
        k++;
      end
    end
    iSTART = 1'b0;
    checkOutput("holdFirstDig", dig1, 64'h09);
    checkOutput("holdSecondDig", dig2, 64'h0100);
    checkOutput("holdSpacing", 64'(t2 - t1), 64'd29);
    checkOutput("holdStable", {63'b0, stable}, 64'h1);

    // Reset at cycle 14 of a conversion of 55.
    repeat (3) @(negedge iCLK);
    iSTART = 1'b1;
    iBIN   = 27'd55;
    @(posedge iCLK);
    @(negedge iCLK);
    iSTART = 1'b0;
    repeat (14) @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    checkOutput("midRstDig", oDIG, 64'h0);
    checkOutput("midRstBusy", {63'b0, oBUSY}, 64'h0);
    checkOutput("midRstOvf", {63'b0, oOVF}, 64'h0);
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge iCLK);
      if (oDONE) doneCnt++;
    end
    checkOutput("midRstNoDone", 64'(doneCnt), 64'd0);
    checkOutput("midRstIdleBusy", {63'b0, oBUSY}, 64'h0);

    applyStimulus(27'd55, -1, -1, lat, busyCnt, doneCnt, dig, ovf, stable, ovf10);
    checkOutput("postRstDig", dig, 64'h0505);
    checkOutput("postRstLatency", 64'(lat), 64'd28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2dig_8.md
Name: bin2dig_8

Overview:
- Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble).
- Sits directly upstream of the 8-digit seven-segment LUT bank and produces its 64-bit packed digit bus.
- Each of the 8 digits occupies one byte: BCD value in bits [3:0] of the byte, upper nibble zero.
- The output register holds the last result steady, so the display never shows intermediate shift states.

Parameters:
- BIN_W, 27, input binary width; 27 bits covers 0..99,999,999.
- MAX_VAL, 99999999, largest displayable value; inputs above this saturate.

Ports:
- iCLK  input  1  system clock, rising edge.
- iRST_N  input  1  asynchronous active-low reset.
- iSTART  input  1  conversion request, sampled on rising edge.
- iBIN  input  BIN_W  binary value, captured on the edge that accepts iSTART.
- oDIG  output  64  packed digits; byte k = digit k (k=0 is least significant); bits [8k+7:8k+4] always 0.
- oBUSY  output  1  high while a conversion is in progress.
- oDONE  output  1  one-cycle pulse when oDIG is updated.
- oOVF  output  1  high when the last accepted iBIN exceeded MAX_VAL; held until the next completion.

Behaviour:
- Reset (async assert, sync-released use): oDIG=64'h0, oBUSY=0, oDONE=0, oOVF=0, FSM=IDLE, internal shift register and counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on iSTART=1 at edge N:
  - capture iBIN into a BIN_W shift register;
  - clear the 32-bit BCD accumulator;
  - bit counter = BIN_W;
  - latch ovf = (iBIN > MAX_VAL);
  - go to SHIFT; oBUSY=1 after edge N.
- SHIFT: each edge, first add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1; decrement the counter.
  - Exactly BIN_W iterations, at edges N+1..N+BIN_W.
  - Go to DONE when the counter reaches 0.
- DONE, edge N+BIN_W+1:
  - oDIG loaded from the accumulator, nibble k into byte k low nibble; if ovf, all 8 bytes = 8'h09.
  - oOVF = ovf; oDONE=1 for exactly this one cycle; oBUSY=0; return to IDLE.
- Latency: iSTART edge to oDIG valid / oDONE high is BIN_W+1 = 28 cycles. Earliest next start is the cycle after oDONE falls. Back-to-back throughput is 1 conversion per 29 cycles.
- iSTART while oBUSY=1 or in DONE: ignored; no queueing and no restart. iBIN changes during a conversion have no effect.
- iSTART held high continuously: a new conversion is accepted each time the FSM returns to IDLE.
- oDIG, oOVF: change only on the DONE edge or reset; stable at all other times.
- Reset mid-conversion: immediate return to reset values; the partial result is discarded; no oDONE pulse.
- Arithmetic:
  - add-3 is per nibble, 4-bit, no carry between nibbles;
  - the accumulator is 32 bits;
  - the MSB shifted out of the accumulator is discarded; this cannot be nonzero for in-range inputs.

Test Plan:
- Reset release, no start -> oDIG=64'h0, oBUSY=0, oDONE=0, oOVF=0 indefinitely.
- iBIN=12345678, single iSTART pulse -> oBUSY high 28 cycles; oDONE at cycle 28; oDIG=64'h0102030405060708; oOVF=0.
- Boundary values:
  - iBIN=0 -> oDIG=64'h0;
  - iBIN=99999999 -> oDIG=64'h0909090909090909, oOVF=0;
  - iBIN=100000000 -> oDIG=64'h0909090909090909, oOVF=1.
- iSTART pulsed again at cycles 5 and 27 of a conversion of 42, with iBIN=7 -> ignored; oDIG=64'h0000000000000402; exactly one oDONE.
- iSTART held high with iBIN=9 then 10 -> conversions complete 29 cycles apart; oDIG sequence 64'h09 then 64'h0100; oDIG stable between oDONE pulses.
- Assert iRST_N low at cycle 14 of a conversion of 55 -> all outputs 0 immediately; no oDONE. A new conversion of 55 after release -> oDIG=64'h0505.
